// File: rtl/board_pkg.sv
// Shared packing constants, tile/state types and a tile lookup helper for the
// board order loader (the random order generator uses the same packing).
package board_pkg;

  localparam int EDGE_N   = 24;
  localparam int CENTER_N = 12;
  localparam int PIC_W    = 4;
  localparam int NUM_PICS = 12;
  localparam int TOTAL_N  = EDGE_N + CENTER_N;
  localparam int IDX_W    = 6;
  localparam int ADDR_W   = 5;

  typedef logic [PIC_W-1:0] pic_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    EVAL,
    WRITE,
    FINISH
  } state_t;

  // Entries 0..EDGE_N-1 address the edge track, the rest address the center.
  function automatic pic_t tile_at(
    input logic [EDGE_N*PIC_W-1:0]   edge_v,
    input logic [CENTER_N*PIC_W-1:0] ctr_v,
    input logic [IDX_W-1:0]          idx
  );
    logic [IDX_W-1:0] cidx;
    if (idx < IDX_W'(EDGE_N)) begin
      return edge_v[idx*PIC_W +: PIC_W];
    end
    cidx = idx - IDX_W'(EDGE_N);
    return ctr_v[cidx*PIC_W +: PIC_W];
  endfunction

endpackage

// File: rtl/tile_histogram.sv
// Per-picture occurrence counters for the edge track and center, plus a sticky
// out-of-range code flag; legal reflects the counters combinationally.
module tile_histogram
  import board_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  input  logic is_center,
  input  pic_t code,
  output logic legal
);

  logic [1:0] edge_cnt [NUM_PICS];
  logic [1:0] ctr_cnt  [NUM_PICS];
  logic       bad_code;

  // Edge counters saturate at 3 and center counters at 2: enough to tell
  // "exactly right" from "too many" without wrapping back to a legal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PICS; p++) begin
        edge_cnt[p] <= '0;
        ctr_cnt[p]  <= '0;
      end
      bad_code <= 1'b0;
    end else if (clear) begin
      for (int p = 0; p < NUM_PICS; p++) begin
        edge_cnt[p] <= '0;
        ctr_cnt[p]  <= '0;
      end
      bad_code <= 1'b0;
    end else if (inc) begin
      if (code >= pic_t'(NUM_PICS)) begin
        bad_code <= 1'b1;
      end else if (is_center) begin
        if (ctr_cnt[code] != 2'd2) ctr_cnt[code] <= ctr_cnt[code] + 2'd1;
      end else begin
        if (edge_cnt[code] != 2'd3) edge_cnt[code] <= edge_cnt[code] + 2'd1;
      end
    end
  end

  always_comb begin
    legal = !bad_code;
    for (int p = 0; p < NUM_PICS; p++) begin
      if (edge_cnt[p] != 2'd2 || ctr_cnt[p] != 2'd1) legal = 1'b0;
    end
  end

endmodule

// File: rtl/board_order_loader.sv
// Captures an edge/center tile order, validates the picture histogram and,
// when legal, streams the 36 placements over a valid/ready write port.
module board_order_loader
  import board_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [EDGE_N*PIC_W-1:0]   edge_order_in,
  input  logic [CENTER_N*PIC_W-1:0] center_order_in,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic                      wr_is_center,
  output logic [ADDR_W-1:0]         wr_addr,
  output pic_t                      wr_pic
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_N - 1);

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic                      err_nxt;
  logic                      capture;
  logic                      hist_clear;
  logic                      hist_inc;
  logic                      hist_legal;
  logic                      wr_valid_int;
  logic [EDGE_N*PIC_W-1:0]   edge_q;
  logic [CENTER_N*PIC_W-1:0] ctr_q;
  pic_t                      cur_pic;
  logic                      cur_is_center;
  logic [ADDR_W-1:0]         cur_addr;
  logic [IDX_W-1:0]          ctr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      err   <= err_nxt;
    end
  end

  // Snapshot of the order; later input changes cannot disturb a load.
  always_ff @(posedge clk) begin
    if (capture) begin
      edge_q <= edge_order_in;
      ctr_q  <= center_order_in;
    end
  end

  assign ctr_idx       = idx - IDX_W'(EDGE_N);
  assign cur_is_center = (idx >= IDX_W'(EDGE_N));
  assign cur_addr      = cur_is_center ? ctr_idx[ADDR_W-1:0] : idx[ADDR_W-1:0];
  assign cur_pic       = tile_at(edge_q, ctr_q, idx);

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    err_nxt      = err;
    capture      = 1'b0;
    hist_clear   = 1'b0;
    hist_inc     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    wr_valid_int = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          hist_clear = 1'b1;
          err_nxt    = 1'b0;
          idx_nxt    = '0;
          state_nxt  = CHECK;
        end
      end
      CHECK: begin
        busy     = 1'b1;
        hist_inc = 1'b1;
        if (idx == LAST_IDX) begin
          idx_nxt   = '0;
          state_nxt = EVAL;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      EVAL: begin
        busy = 1'b1;
        if (hist_legal) begin
          idx_nxt   = '0;
          state_nxt = WRITE;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = FINISH;
        end
      end
      WRITE: begin
        busy         = 1'b1;
        wr_valid_int = 1'b1;
        if (wr_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = FINISH;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write fields read as zero whenever no request is presented.
  assign wr_valid     = wr_valid_int;
  assign wr_is_center = wr_valid_int & cur_is_center;
  assign wr_addr      = wr_valid_int ? cur_addr : '0;
  assign wr_pic       = wr_valid_int ? cur_pic : '0;

  tile_histogram u_hist (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (hist_clear),
    .inc       (hist_inc),
    .is_center (cur_is_center),
    .code      (cur_pic),
    .legal     (hist_legal)
  );

endmodule

// File: tb/tb_board_order_loader.sv
// Scoreboard bench for board_order_loader: stimulus pushes expected writes and
// done events, a negedge monitor pops and compares them.
module tb_board_order_loader;
  import board_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      start;
  logic [EDGE_N*PIC_W-1:0]   edge_v;
  logic [CENTER_N*PIC_W-1:0] ctr_v;
  logic                      busy, done, err, wr_valid, wr_ready, wr_is_center;
  logic [ADDR_W-1:0]         wr_addr;
  pic_t                      wr_pic;

  typedef struct {
    logic              c;
    logic [ADDR_W-1:0] a;
    pic_t              p;
  } wr_t;

  typedef struct {
    int   cyc;
    logic e;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int  cyc      = 0;
  int  n_cmp    = 0;
  int  n_bad    = 0;
  int  hs_cnt   = 0;
  int  last_hs  = -10;
  int  deadline = 0;
  bit  bp_mode  = 1'b0;

  board_order_loader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .edge_order_in   (edge_v),
    .center_order_in (ctr_v),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_is_center    (wr_is_center),
    .wr_addr         (wr_addr),
    .wr_pic          (wr_pic)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Consumer: ready always, or 1,0,0 repeating under backpressure.
  initial begin
    int rp;
    rp = 0;
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      wr_ready = bp_mode ? (rp % 3 == 0) : 1'b1;
      rp++;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      n_cmp++;
      if ({busy, done, err, wr_valid, wr_is_center, wr_addr, wr_pic} != '0) begin
        n_bad++;
        $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b vld=%0b ctr=%0b addr=%0d pic=%0d, required all 0",
                 busy, done, err, wr_valid, wr_is_center, wr_addr, wr_pic);
      end
    end else begin
      if (wr_valid) begin
        n_cmp++;
        if (wq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: ctr=%0b addr=%0d pic=%0d at cyc %0d, required no write",
                   wr_is_center, wr_addr, wr_pic, cyc);
        end else begin
          if (wr_is_center !== wq[0].c || wr_addr !== wq[0].a || wr_pic !== wq[0].p) begin
            n_bad++;
            $display("FAIL write_fields: got ctr=%0b addr=%0d pic=%0d, required ctr=%0b addr=%0d pic=%0d",
                     wr_is_center, wr_addr, wr_pic, wq[0].c, wq[0].a, wq[0].p);
          end
          if (wr_ready) begin
            void'(wq.pop_front());
            hs_cnt++;
            last_hs = cyc;
          end
        end
      end
      if (done) begin
        n_cmp++;
        if (dq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: at cyc %0d, required no done", cyc);
        end else begin
          dn_t d;
          int  want;
          d = dq.pop_front();
          want = (d.cyc < 0) ? last_hs + 1 : d.cyc;
          if (cyc != want || err !== d.e || busy !== 1'b0 || wq.size() != 0) begin
            n_bad++;
            $display("FAIL done_event: cyc=%0d err=%0b busy=%0b pending_writes=%0d, required cyc=%0d err=%0b busy=0 pending=0",
                     cyc, err, busy, wq.size(), want, d.e);
          end
        end
      end
      if (dq.size() > 0 && cyc > deadline) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: no done by cyc %0d, required done with %0d writes pending", cyc, wq.size());
        dq.delete();
        wq.delete();
      end
    end
  end

  task automatic launch(input logic [EDGE_N*PIC_W-1:0] ev, input logic [CENTER_N*PIC_W-1:0] cv,
                        input bit legal, input int done_off);
    dn_t d;
    @(posedge clk);
    #1;
    edge_v = ev;
    ctr_v  = cv;
    start  = 1'b1;
    if (legal) begin
      for (int i = 0; i < EDGE_N; i++) wq.push_back('{1'b0, ADDR_W'(i), ev[i*PIC_W +: PIC_W]});
      for (int i = 0; i < CENTER_N; i++) wq.push_back('{1'b1, ADDR_W'(i), cv[i*PIC_W +: PIC_W]});
    end
    d.cyc = (done_off < 0) ? -1 : cyc + done_off;
    d.e   = !legal;
    dq.push_back(d);
    deadline = cyc + 400;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 1000 && dq.size() > 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
  endtask

  logic [EDGE_N*PIC_W-1:0]   lev, bev;
  logic [CENTER_N*PIC_W-1:0] lcv, bcv;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    edge_v = '0;
    ctr_v  = '0;
    for (int i = 0; i < EDGE_N; i++) lev[i*PIC_W +: PIC_W] = pic_t'(i / 2);
    for (int i = 0; i < CENTER_N; i++) lcv[i*PIC_W +: PIC_W] = pic_t'(11 - i);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Legal board, ready tied high: done 74 cycles after the start cycle.
    launch(lev, lcv, 1'b1, 74);
    wait_idle();

    // Same board under backpressure.
    bp_mode = 1'b1;
    launch(lev, lcv, 1'b1, -1);
    wait_idle();
    bp_mode = 1'b0;

    // Center tile 7 (picture 4) replaced by 3: picture 3 twice, picture 4 missing.
    bev = lev;
    bcv = lcv;
    bcv[7*PIC_W +: PIC_W] = 4'd3;
    launch(bev, bcv, 1'b0, 38);
    wait_idle();

    // Out-of-range code on edge tile 0.
    bev = lev;
    bev[0 +: PIC_W] = 4'hF;
    launch(bev, lcv, 1'b0, 38);
    wait_idle();

    // Inputs zeroed at cycle 2 and a stray start at cycle 10 must not matter.
    launch(lev, lcv, 1'b1, 74);
    #1;
    @(posedge clk);
    #1;
    edge_v = '0;
    ctr_v  = '0;
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Reset after 10 handshakes, then a full reload.
    hs_cnt = 0;
    launch(lev, lcv, 1'b1, 74);
    for (int k = 0; k < 300 && hs_cnt < 10; k++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    wq.delete();
    dq.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    launch(lev, lcv, 1'b1, 74);
    wait_idle();

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
